// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode selectors,
// the FWFT prefetch state encoding and an elaboration-time log2 helper.
package fifo_pkg;

   localparam int READ_MODE_STD  = 0;
   localparam int READ_MODE_FWFT = 1;

   // Status of the word presented at the FIFO output in FWFT mode.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,  // nothing presented, no read in flight
      ST_PREFETCH = 2'd1,  // head read from RAM this cycle
      ST_VALID    = 2'd2   // head presented on rdata, rdv=1
   } fwft_state_e;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer bundle of the single-clock FIFO.
// Handshake: a write is accepted on a cycle with wdv=1 and wfull=0; a read is
// accepted on a cycle with rrq=1 and rempty=0. wfull/rempty depend only on
// FIFO registers, so requesters may hold wdv/rrq high and simply retry.
interface sync_fifo_fwft_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
);
   import fifo_pkg::*;

   logic              clr;
   logic              wdv;
   logic [DWIDTH-1:0] wdata;
   logic              wfull;
   logic              afull;
   logic              rrq;
   logic [DWIDTH-1:0] rdata;
   logic              rdv;
   logic              rempty;
   logic              aempty;
   logic [AWIDTH:0]   count;
   logic              ovf;
   logic              udf;
   fwft_state_e       dbg_state;

   // User side: drives requests, observes status and data.
   modport master (
      output clr, wdv, wdata, rrq,
      input  wfull, afull, rdata, rdv, rempty, aempty, count, ovf, udf, dbg_state
   );

   // FIFO side.
   modport slave (
      input  clr, wdv, wdata, rrq,
      output wfull, afull, rdata, rdv, rempty, aempty, count, ovf, udf, dbg_state
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage, one clock, registered read. The storage array has
// no reset so it maps onto block or distributed RAM; only the read register
// is reset/flushed so rdata starts from zero.
module sync_fifo_ram #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
) (
   input  logic              i_clk,
   input  logic              i_arst_n,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [AWIDTH-1:0] i_waddr,
   input  logic [DWIDTH-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AWIDTH-1:0] i_raddr,
   output logic [DWIDTH-1:0] o_rdata
);

   logic [DWIDTH-1:0] r_mem [0:(1<<AWIDTH)-1];
   logic [DWIDTH-1:0] r_rdata;

   // Write port: store the word on an accepted write.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: load the addressed word when a read is issued, else hold.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_rdata <= '0;
      end else if (i_clr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// fill count, almost flags, sticky overflow/underflow and synchronous flush.
// The RAM read register doubles as the output register in both modes.
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int DEPTH     = 16,
   parameter int AWIDTH    = 4,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 4
) (
   input logic             clk,
   input logic             arst_n,
   sync_fifo_fwft_if.slave bus
);

   localparam int CW = AWIDTH + 1;
   localparam bit IS_FWFT = (FWFT == READ_MODE_FWFT);
   localparam logic [AWIDTH:0] C_DEPTH  = CW'(DEPTH);
   localparam logic [AWIDTH:0] C_AFULL  = CW'(AFULL_TH);
   localparam logic [AWIDTH:0] C_AEMPTY = CW'(AEMPTY_TH);

   // Parameter sanity, rejected at elaboration.
   generate
      if (AWIDTH != clog2(DEPTH)) begin : g_bad_awidth
         $fatal(1, "sync_fifo_fwft: AWIDTH must equal clog2(DEPTH)");
      end
      if (((1 << AWIDTH) != DEPTH) || (DEPTH < 4)) begin : g_bad_depth
         $fatal(1, "sync_fifo_fwft: DEPTH must be a power of two >= 4");
      end
      if ((FWFT != READ_MODE_STD) && (FWFT != READ_MODE_FWFT)) begin : g_bad_mode
         $fatal(1, "sync_fifo_fwft: FWFT must be 0 or 1");
      end
      if ((AFULL_TH < 1) || (AFULL_TH > DEPTH) || (AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_th
         $fatal(1, "sync_fifo_fwft: threshold out of range");
      end
   endgenerate

   logic [AWIDTH:0]   r_wptr;
   logic [AWIDTH:0]   r_rptr;
   logic [AWIDTH:0]   r_count;
   logic              r_ovf;
   logic              r_udf;
   logic              r_rdv;
   fwft_state_e       r_state;

   logic              w_wfull;
   logic              w_rempty;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_mem_nonempty;
   logic              w_ram_re;
   logic [DWIDTH-1:0] w_ram_rdata;

   // Status derived from registers only; requests never reach an output.
   assign w_wfull        = (r_count == C_DEPTH);
   assign w_rempty       = IS_FWFT ? !r_rdv : (r_count == '0);
   assign w_mem_nonempty = (r_wptr != r_rptr);

   // clr wins over both requests in its cycle.
   assign w_wr_acc = bus.wdv && !w_wfull  && !bus.clr;
   assign w_rd_acc = bus.rrq && !w_rempty && !bus.clr;

   // RAM read issue: standard mode reads on each accepted read; FWFT mode
   // reads during PREFETCH and when an acknowledged word has a successor.
   always_comb begin
      w_ram_re = w_rd_acc;
      if (IS_FWFT) begin
         w_ram_re = !bus.clr &&
                    ((r_state == ST_PREFETCH) ||
                     ((r_state == ST_VALID) && w_rd_acc && w_mem_nonempty));
      end
   end

   sync_fifo_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .i_clr    (bus.clr),
      .i_we     (w_wr_acc),
      .i_waddr  (r_wptr[AWIDTH-1:0]),
      .i_wdata  (bus.wdata),
      .i_re     (w_ram_re),
      .i_raddr  (r_rptr[AWIDTH-1:0]),
      .o_rdata  (w_ram_rdata)
   );

   // Pointers: extra MSB separates full from empty, wrap is modulo 2*DEPTH.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (bus.clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
         if (w_ram_re) r_rptr <= r_rptr + 1'b1;
      end
   end

   // Fill count, including a word held in the output register in FWFT mode.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_count <= '0;
      end else if (bus.clr) begin
         r_count <= '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         r_count <= r_count + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Sticky error flags: request made while the matching side was blocked.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else if (bus.clr) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (bus.wdv && w_wfull)  r_ovf <= 1'b1;
         if (bus.rrq && w_rempty) r_udf <= 1'b1;
      end
   end

   // Output-valid control: one-cycle pulse in standard mode, prefetch FSM in
   // FWFT mode. When the last word is acknowledged in the same cycle a new
   // word is written, go straight to PREFETCH so that word still shows up two
   // cycles after its write.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= ST_IDLE;
         r_rdv   <= 1'b0;
      end else if (bus.clr) begin
         r_state <= ST_IDLE;
         r_rdv   <= 1'b0;
      end else if (!IS_FWFT) begin
         r_state <= ST_IDLE;
         r_rdv   <= w_rd_acc;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rdv <= 1'b0;
               if (w_mem_nonempty || w_wr_acc) r_state <= ST_PREFETCH;
            end
            ST_PREFETCH: begin
               r_state <= ST_VALID;
               r_rdv   <= 1'b1;
            end
            ST_VALID: begin
               if (w_rd_acc && !w_mem_nonempty) begin
                  r_rdv   <= 1'b0;
                  r_state <= w_wr_acc ? ST_PREFETCH : ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_rdv   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wfull     = w_wfull;
   assign bus.afull     = (r_count >= C_AFULL);
   assign bus.rempty    = w_rempty;
   assign bus.aempty    = (r_count <= C_AEMPTY);
   assign bus.count     = r_count;
   assign bus.rdata     = w_ram_rdata;
   assign bus.rdv       = r_rdv;
   assign bus.ovf       = r_ovf;
   assign bus.udf       = r_udf;
   assign bus.dbg_state = r_state;

endmodule
